// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: valid/ready word intake, start + LSB-first data + optional parity
// + 1/2 stop bits on TX_OUT, bit timing from a per-frame latched prescale down-counter.
module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     P_Data,
    input  logic                      D_Valid,
    output logic                      D_Ready,
    input  logic                      Parity_EN,
    input  logic                      Parity_Type,
    input  logic                      Stop2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      Frame_Done
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [BIT_W-1:0]          r_bit;
    logic                      r_par_en;
    logic                      r_par_bit;
    logic                      r_stop2;
    logic                      r_last_stop;

    logic w_xfer;
    logic w_tick;
    logic w_last_bit;
    logic w_presc_zero;
    logic w_enter_stop1;
    logic w_enter_last;

    assign w_xfer       = D_Valid & D_Ready;
    assign w_tick       = (r_cnt == '0);
    assign w_last_bit   = (r_bit == BIT_W'(DATA_WIDTH - 1));
    assign w_presc_zero = (r_presc == '0);

    always_comb begin
        w_enter_stop1 = 1'b0;
        w_enter_last  = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_DATA: begin
                    w_enter_stop1 = w_last_bit & ~r_par_en & r_stop2;
                    w_enter_last  = w_last_bit & ~r_par_en & ~r_stop2;
                end
                S_PARITY: begin
                    w_enter_stop1 = r_stop2;
                    w_enter_last  = ~r_stop2;
                end
                S_STOP:  w_enter_last = ~r_last_stop;
                default: ;
            endcase
        end
    end

    // The final cycle of the last stop bit is spent in IDLE with Frame_Done high, so the
    // last stop bit runs one cycle short in STOP and a back-to-back word starts with no gap.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
            Frame_Done  <= 1'b0;
            D_Ready     <= 1'b1;
            r_shift     <= '0;
            r_presc     <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            r_last_stop <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    TX_OUT <= 1'b1;
                    if (w_xfer) begin
                        r_state     <= S_START;
                        TX_OUT      <= 1'b0;
                        busy        <= 1'b1;
                        D_Ready     <= 1'b0;
                        r_shift     <= P_Data;
                        r_presc     <= Prescale;
                        r_cnt       <= Prescale;
                        r_par_en    <= Parity_EN;
                        r_par_bit   <= ^P_Data ^ Parity_Type;
                        r_stop2     <= Stop2;
                        r_last_stop <= 1'b0;
                        r_bit       <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        TX_OUT  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_cnt   <= r_presc;
                    end else begin
                        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
                    end else if (!w_last_bit) begin
                        TX_OUT  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + BIT_W'(1);
                        r_cnt   <= r_presc;
                    end else if (r_par_en) begin
                        r_state <= S_PARITY;
                        TX_OUT  <= r_par_bit;
                        r_cnt   <= r_presc;
                    end
                end
                S_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
                    end else if (r_last_stop) begin
                        r_state    <= S_IDLE;
                        TX_OUT     <= 1'b1;
                        busy       <= 1'b0;
                        D_Ready    <= 1'b1;
                        Frame_Done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    D_Ready <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase

            if (w_enter_last) begin
                TX_OUT <= 1'b1;
                if (w_presc_zero) begin
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                    D_Ready    <= 1'b1;
                    Frame_Done <= 1'b1;
                end else begin
                    r_state     <= S_STOP;
                    r_cnt       <= r_presc - PRESCALE_WIDTH'(1);
                    r_last_stop <= 1'b1;
                end
            end else if (w_enter_stop1) begin
                r_state     <= S_STOP;
                TX_OUT      <= 1'b1;
                r_cnt       <= r_presc;
                r_last_stop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: table of hand-derived frames, reset/abort sequence,
// and random frames checked cycle by cycle against a queue-based frame model.
module tb_uart_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  p_data;
    logic        dv8, dv5;
    logic        pen, ptype, stop2;
    logic [15:0] presc;
    logic        rdy8, tx8, busy8, done8;
    logic        rdy5, tx5, busy5, done5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut8 (
        .Clk(clk), .Reset(rst_n), .P_Data(p_data), .D_Valid(dv8), .D_Ready(rdy8),
        .Parity_EN(pen), .Parity_Type(ptype), .Stop2(stop2), .Prescale(presc),
        .TX_OUT(tx8), .busy(busy8), .Frame_Done(done8)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(5), .PRESCALE_WIDTH(16)) dut5 (
        .Clk(clk), .Reset(rst_n), .P_Data(p_data[4:0]), .D_Valid(dv5), .D_Ready(rdy5),
        .Parity_EN(pen), .Parity_Type(ptype), .Stop2(stop2), .Prescale(presc),
        .TX_OUT(tx5), .busy(busy5), .Frame_Done(done5)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [7:0]  d;
        bit          pe, pt, s2;
        logic [15:0] ps;
        bit          perturb, hold;
        logic [7:0]  nd;
        int          gap;
        logic [15:0] fr;
        int          nbits;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {tx5, busy5, rdy5, done5} : {tx8, busy8, rdy8, done8};
    endfunction

    task automatic check(input string name, input int k, input logic [3:0] got,
                         input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: tx/busy/rdy/done got %b expected %b",
                     name, k, got, exp);
        end
    endtask

    // Frame as a list of line levels, one per bit period, built from the framing rules.
    function automatic int model(input logic [7:0] d, input int dw, input bit pe,
                                 input bit pt, input bit s2, output logic [15:0] fr);
        bit q[$];
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        fr = '0;
        for (int i = 0; i < q.size(); i++) fr[i] = q[i];
        return q.size();
    endfunction

    task automatic idle(input string name, input int n);
        dv8 = 1'b0;
        dv5 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({name, "_idle8"}, i, obs(1'b0), 4'b1010);
            check({name, "_idle5"}, i, obs(1'b1), 4'b1010);
        end
    endtask

    task automatic run_frame(input string name, input bit sel, input logic [7:0] d,
                             input bit pe, input bit pt, input bit s2,
                             input logic [15:0] ps, input logic [15:0] fr, input int nbits,
                             input bit perturb, input bit hold, input logic [7:0] nd,
                             input int abort_k);
        int pp;
        int len;
        logic [3:0] exp;
        pp  = int'(ps) + 1;
        len = nbits * pp;
        p_data = d; pen = pe; ptype = pt; stop2 = s2; presc = ps;
        if (sel) dv5 = 1'b1; else dv8 = 1'b1;
        @(posedge clk); #1;
        if (hold) p_data = nd;
        else begin dv8 = 1'b0; dv5 = 1'b0; end
        for (int k = 1; k <= len; k++) begin
            exp = {fr[(k - 1) / pp], k < len, k == len, k == len};
            check(name, k, obs(sel), exp);
            if (k == abort_k) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check({name, "_rst"}, k, obs(sel), 4'b1010);
                rst_n = 1'b1;
                return;
            end
            if (perturb && k < len) begin
                p_data = 8'($urandom);
                pen    = 1'($urandom);
                ptype  = 1'($urandom);
                stop2  = 1'($urandom);
                presc  = 16'($urandom_range(0, 7));
                if (sel) dv5 = 1'($urandom); else dv8 = 1'($urandom);
            end
            if (k == len && !hold) begin dv8 = 1'b0; dv5 = 1'b0; end
            if (k < len) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] fr;
        int          nb;
        bit          sel, pe, pt, s2, pert;
        logic [7:0]  d;
        logic [15:0] ps;
        int          gap;

        tbl[0]  = '{"a5_8n1",     1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'h00, 0, 16'h034A, 10};
        tbl[1]  = '{"01_8e2_p3",  1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 8'h00, 1, 16'h0E02, 12};
        tbl[2]  = '{"a5_8o1_p1",  1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 8'h00, 0, 16'h074A, 11};
        tbl[3]  = '{"a5_8e1",     1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'h00, 2, 16'h054A, 11};
        tbl[4]  = '{"b2b_11",     1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 8'h22, 1, 16'h0222, 10};
        tbl[5]  = '{"b2b_22",     1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'h00, 0, 16'h0244, 10};
        tbl[6]  = '{"ff_8e2",     1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 8'h00, 0, 16'h0DFE, 12};
        tbl[7]  = '{"00_8o1_p2",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 8'h00, 0, 16'h0600, 11};
        tbl[8]  = '{"3c_pert_p2", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'h00, 1, 16'h0278, 10};
        tbl[9]  = '{"w5_15_pert", 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'h00, 1, 16'h006A, 7};
        tbl[10] = '{"w5_15_n1",   1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'h00, 0, 16'h006A, 7};

        rst_n = 1'b0; dv8 = 1'b0; dv5 = 1'b0;
        p_data = 8'h00; pen = 1'b0; ptype = 1'b0; stop2 = 1'b0; presc = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset8", 0, obs(1'b0), 4'b1010);
        check("reset5", 0, obs(1'b1), 4'b1010);
        rst_n = 1'b1;
        idle("post_reset", 2);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].gap > 0) idle(tbl[i].name, tbl[i].gap);
            run_frame(tbl[i].name, tbl[i].sel, tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].s2,
                      tbl[i].ps, tbl[i].fr, tbl[i].nbits, tbl[i].perturb, tbl[i].hold,
                      tbl[i].nd, 0);
        end

        // Reset during data bit 3 (bit period 4 at two cycles per bit), then a clean frame.
        idle("pre_abort", 1);
        run_frame("abort", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'd1, 16'h034A, 10,
                  1'b0, 1'b0, 8'h00, 9);
        idle("after_abort", 3);
        run_frame("post_abort", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'd1, 16'h034A, 10,
                  1'b0, 1'b0, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            sel  = ($urandom_range(0, 3) == 0);
            d    = 8'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            s2   = 1'($urandom);
            ps   = 16'($urandom_range(0, 3));
            pert = 1'($urandom);
            gap  = int'($urandom_range(0, 2));
            nb   = model(d, sel ? 5 : 8, pe, pt, s2, fr);
            if (gap > 0) idle("rand", gap);
            run_frame("rand", sel, d, pe, pt, s2, ps, fr, nb, pert, 1'b0, 8'h00, 0);
        end

        idle("final", 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
